// File: rtl/uart_tx_frame_if.sv
// Parallel-side bus of the UART transmitter: byte request, parity select and serial/status outputs.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional even/odd parity, one stop bit.
// One serial bit per clk; a new byte may be accepted in the stop cycle for gapless frames.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_frame_if.slave  bus
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  accept;
  logic [CW-1:0]         cnt_inc;
  logic                  parity;

  // Outputs are computed for the state being entered, so they register on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    accept  = bus.DATA_VALID && ((state_q == IDLE) || (state_q == STOP));
    cnt_inc = cnt_q + 1'b1;
    parity  = par_typ_q ? ~^data_q : ^data_q;

    if (accept) begin
      data_d    = bus.P_DATA;
      par_en_d  = bus.PAR_EN;
      par_typ_d = bus.PAR_TYP;
    end

    case (state_q)
      IDLE, STOP: begin
        if (accept) begin
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        tx_d    = data_q[0];
        busy_d  = 1'b1;
      end
      DATA: begin
        busy_d = 1'b1;
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = parity;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
          tx_d  = data_q[cnt_inc];
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: each driven cycle queues the expected TX_OUT/Busy,
// and an independent monitor pops and compares after every rising edge.
module tb_uart_tx_frame;

  logic clk;
  logic rst;

  uart_tx_frame_if #(.DATA_WIDTH(8)) bus_if ();

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic  tx;
    logic  busy;
    string tag;
    bit    lb;
  } exp_t;

  exp_t sb[$];
  logic lb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic compare(input string name, input logic [15:0] act, input logic [15:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expectation per rising edge, checked shortly after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compare({e.tag, "_tx"}, 16'(bus_if.TX_OUT), 16'(e.tx));
        compare({e.tag, "_busy"}, 16'(bus_if.Busy), 16'(e.busy));
        if (e.lb) lb_q.push_back(bus_if.TX_OUT);
      end
    end
  end

  task automatic apply_stimulus(input bit r, input bit dv, input logic [7:0] d,
                                input bit pen, input bit ptyp,
                                input bit etx, input bit ebusy,
                                input string tag, input bit lb);
    exp_t e;
    @(negedge clk);
    rst               = r;
    bus_if.DATA_VALID = dv;
    bus_if.P_DATA     = d;
    bus_if.PAR_EN     = pen;
    bus_if.PAR_TYP    = ptyp;
    e.tx   = etx;
    e.busy = ebusy;
    e.tag  = tag;
    e.lb   = lb;
    sb.push_back(e);
  endtask

  // Drives one frame; after the accept cycle the inputs are deliberately scrambled.
  task automatic send_frame(input logic [7:0] d, input bit pen, input bit ptyp,
                            input logic [10:0] bits, input int len, input string tag,
                            input int glitch_at, input int rst_at, input bit lb);
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) begin
        apply_stimulus(1'b1, 1'b1, d, pen, ptyp, 1'b1, 1'b0, {tag, "_rst"}, 1'b0);
        return;
      end
      if (i == 0)
        apply_stimulus(1'b0, 1'b1, d, pen, ptyp, bits[len-1], 1'b1, tag, lb);
      else
        apply_stimulus(1'b0, (i == glitch_at), ~d, ~pen, ~ptyp, bits[len-1-i], 1'b1, tag, lb);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++)
      apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, tag, 1'b0);
  endtask

  // Loopback receiver: rebuild the 0x07 frame and check its even parity.
  task automatic check_output();
    logic [7:0] rx_data;
    logic       par_err;
    compare("loop_len", 16'(lb_q.size()), 16'd11);
    if (lb_q.size() == 11) begin
      for (int i = 0; i < 8; i++) rx_data[i] = lb_q[1+i];
      par_err = ^{rx_data, lb_q[9]};
      compare("loop_start", 16'(lb_q[0]), 16'd0);
      compare("loop_data", 16'(rx_data), 16'h07);
      compare("loop_par_err", 16'(par_err), 16'd0);
      compare("loop_stop", 16'(lb_q[10]), 16'd1);
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus_if.DATA_VALID = 1'b0;
    bus_if.P_DATA     = 8'h00;
    bus_if.PAR_EN     = 1'b0;
    bus_if.PAR_TYP    = 1'b0;

    apply_stimulus(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, "rst_dv", 1'b0);
    apply_stimulus(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, "rst_dv", 1'b0);
    idle(2, "post_rst");

    send_frame(8'hA5, 1'b0, 1'b0, 11'b01010010110 >> 1, 10, "a5_nopar", -1, -1, 1'b0);
    idle(2, "a5_idle");

    send_frame(8'hA5, 1'b1, 1'b0, 11'b01010010101, 11, "a5_even", -1, -1, 1'b0);
    idle(1, "even_idle");
    send_frame(8'hA5, 1'b1, 1'b1, 11'b01010010111, 11, "a5_odd", -1, -1, 1'b0);
    idle(1, "odd_idle");

    send_frame(8'h07, 1'b1, 1'b0, 11'b01110000011, 11, "p07_even", -1, -1, 1'b1);
    idle(2, "p07_idle");
    @(posedge clk);
    #3;
    check_output();

    send_frame(8'h55, 1'b0, 1'b0, 11'b00101010101, 10, "b2b_55", -1, -1, 1'b0);
    send_frame(8'hAA, 1'b0, 1'b0, 11'b00010101011, 10, "b2b_aa", -1, -1, 1'b0);
    idle(2, "b2b_idle");

    send_frame(8'hA5, 1'b0, 1'b0, 11'b00101001011, 10, "glitch", 4, -1, 1'b0);
    idle(3, "no_second");

    send_frame(8'hA5, 1'b0, 1'b0, 11'b00101001011, 10, "mid", -1, 5, 1'b0);
    idle(2, "mid_idle");
    send_frame(8'hA5, 1'b1, 1'b1, 11'b01010010111, 11, "after_rst", -1, -1, 1'b0);
    idle(2, "final_idle");

    @(posedge clk);
    #3;
    compare("sb_drain", 16'(sb.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter: serializes one parallel byte per frame onto a single line, with optional parity.
- Frame format: start bit, data bits LSB first, optional parity bit, one stop bit.
- Sits opposite the UART RX chain. Uses the same PAR_EN/PAR_TYP encoding as the RX parity checker: PAR_TYP=0 even, PAR_TYP=1 odd.
- clk is the bit clock: one serial bit per clk cycle. Baud prescaling is done upstream.

Parameters:
- DATA_WIDTH, 8: number of data bits per frame.

Ports:
- clk  input  1  bit clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- P_DATA  input  DATA_WIDTH  parallel byte to send; sampled only on accept
- DATA_VALID  input  1  request to send P_DATA
- PAR_EN  input  1  1 = insert parity bit; sampled on accept
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept
- TX_OUT  output  1  serial line; idles high; registered
- Busy  output  1  high while a frame is on the line; registered

Behaviour:
- Reset: one clock; synchronous and active-high (rst=1 at a rising edge).
  - Effect: state=IDLE, TX_OUT=1, Busy=0, bit counter=0, shift/latch registers cleared.
  - Reset has priority over everything, including mid-frame. The frame is truncated; the line returns high at that edge.
- Accept: DATA_VALID=1 at a rising edge while state is IDLE or STOP.
  - Latches P_DATA, PAR_EN and PAR_TYP into internal registers.
  - DATA_VALID in any other state is ignored (no queueing).
  - Input changes after accept do not affect the frame in flight.
- Parity: computed from the latched data.
  - Even: par = ^data.
  - Odd: par = ~^data.
- FSM states, with the TX_OUT/Busy value driven during each state:
  - IDLE (1/0): on accept -> START; otherwise stay.
  - START (0/1): -> DATA after 1 cycle.
  - DATA (data[cnt]/1): cnt runs 0..DATA_WIDTH-1, LSB first, one bit per cycle. At cnt=DATA_WIDTH-1 -> PARITY if latched PAR_EN=1, else -> STOP. cnt resets to 0 on leaving DATA.
  - PARITY (par/1): -> STOP after 1 cycle.
  - STOP (1/1): on accept -> START (back-to-back; Busy stays 1, no idle gap); else -> IDLE.
- Output timing: TX_OUT and Busy are registered and change on the same edge as the state.
  - Accept at edge N: TX_OUT=0 and Busy=1 from edge N.
  - data[0] from edge N+1.
  - Stop bit from edge N+1+DATA_WIDTH (no parity) or N+2+DATA_WIDTH (parity).
- Frame length: DATA_WIDTH+2 cycles without parity; DATA_WIDTH+3 with parity (10 or 11 for DATA_WIDTH=8).
- Busy falls on the edge leaving STOP to IDLE, i.e. after exactly one full stop-bit cycle.
- No glitches: TX_OUT changes only on rising clk edges.
- Boundary cases:
  - rst and DATA_VALID both high: reset wins; no frame starts.
  - DATA_VALID held high continuously: frames repeat back-to-back. P_DATA is resampled at each STOP-cycle accept.
  - PAR_EN toggled mid-frame: no effect until the next accept.

Test Plan:
- Reset, then P_DATA=0xA5, PAR_EN=0, one-cycle DATA_VALID -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop); Busy high exactly 10 cycles; then TX_OUT=1, Busy=0.
- P_DATA=0xA5 with PAR_EN=1: PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1. Frame is 11 cycles.
- P_DATA=0x07, PAR_EN=1, PAR_TYP=0 -> parity bit 1; a loopback into the UART RX reports par_err=0.
- DATA_VALID high in the STOP cycle of a 0x55 frame with P_DATA=0xAA -> 0xAA start bit on the next cycle. Busy never drops; no idle bit between frames.
- Change P_DATA and pulse DATA_VALID mid-frame (in the DATA state) -> ignored; the original byte completes; no second frame.
- Assert rst during DATA bit 3 -> TX_OUT=1 and Busy=0 from that edge. A new accept afterwards produces a clean full frame.
